cache_write_buffer: RTL and testbench
=====================================

Name: cache_write_buffer

Overview:
- Posted write buffer between the write-through direct-mapped cache and main memory.
- Accepts every store the cache sends to memory and queues it in order.
- Drains entries to memory over a req/ack handshake, so the cache never waits on memory write latency.
- Provides a combinational forwarding lookup, so a cache read miss returns data still held in the buffer and never stale memory.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, >= 2.
- ADDR_W, 32, address width; bits [1:0] are ignored (word granularity).
- DATA_W, 32, data width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- wr_valid  input  1  cache presents a store.
- wr_ready  output  1  buffer can accept the store this cycle.
- wr_addr  input  ADDR_W  store byte address.
- wr_data  input  DATA_W  store data.
- lk_addr  input  ADDR_W  forwarding lookup address (cache miss address).
- fwd_hit  output  1  lk_addr word matches a valid entry.
- fwd_data  output  DATA_W  data of the youngest matching entry; 0 when no hit.
- mem_req  output  1  write request to memory (registered).
- mem_addr  output  ADDR_W  head entry address, bits [1:0] forced to 0.
- mem_wdata  output  DATA_W  head entry data.
- mem_ack  input  1  memory accepted the write (one-cycle pulse).
- count  output  $clog2(DEPTH+1)  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Reset (async): entries invalid; wr_ptr = rd_ptr = 0; state IDLE; mem_req = 0; count = 0; empty = 1; full = 0.
- Storage: circular FIFO with wr_ptr/rd_ptr wrapping at DEPTH; count register.
- Push: wr_valid && wr_ready at an edge writes {addr[ADDR_W-1:2], data} at wr_ptr, then increments wr_ptr and count. Visible in count/fwd from the next cycle.
- wr_ready = !full (combinational). A pop in the same cycle does not free a slot for that cycle's push.
- Drain FSM (states IDLE and REQ):
  - IDLE: if !empty, go to REQ and set mem_req = 1 at that edge.
  - REQ: mem_req, mem_addr and mem_wdata are held stable and show the head entry.
  - REQ with mem_ack at an edge: pop the head, increment rd_ptr, decrement count, clear mem_req, return to IDLE.
  - Throughput: at most one entry per 2 cycles. Minimum latency from push edge to mem_req high is 1 cycle.
  - mem_ack in IDLE is ignored.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Forwarding (combinational):
  - Compare lk_addr[ADDR_W-1:2] with every valid entry, including the head being drained.
  - The youngest match (closest to wr_ptr) wins.
  - An entry pushed at the current edge is not visible until the following cycle.
- Ordering: memory receives writes strictly in acceptance order. No reordering.
- Reset mid-REQ: outstanding entries are discarded and mem_req drops immediately. A late mem_ack after reset is ignored.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined:
  - An accepted store whose word address matches a valid entry overwrites that entry's data in place; no new entry, count unchanged.
  - The youngest matching entry is used.
  - Exception: the head entry while state == REQ is never modified; a store to that address allocates a new entry.
  - wr_ready = !full || coalescible_match, so a coalescing store is accepted when full.
- Not defined: every accepted store allocates a new entry; wr_ready = !full.

Test Plan:
- Reset: assert reset mid-cycle -> count=0, empty=1, full=0, mem_req=0, wr_ready=1 immediately.
- Fill: mem_ack=0; push 0x100/0xA, 0x104/0xB, 0x108/0xC, 0x10C/0xD -> full=1, wr_ready=0, count=4; mem_req=1 with mem_addr=0x100, mem_wdata=0xA held stable.
- Drain: pulse mem_ack whenever mem_req=1 -> memory sees 0x100..0x10C in order with data A..D, 2 cycles per write; ends with empty=1, mem_req=0.
- Forwarding: mem_ack=0; push 0x200/0x11, then 0x200/0x22, then lk_addr=0x203 -> fwd_hit=1, fwd_data=0x22 (macro off, count=2). lk_addr=0x204 -> fwd_hit=0, fwd_data=0.
- Coalesce (WB_COALESCE_EN): mem_ack=0; push 0x300/1, 0x304/2, 0x304/3 -> count=2. Drain writes 0x300=1, then 0x304=3.
- Reset during REQ with 3 entries queued -> mem_req=0, count=0; a mem_ack the next cycle produces no pop and no underflow.

Source files
------------

// File: rtl/cache_write_buffer.sv
// cache_write_buffer
//   Posted write buffer between a write-through direct-mapped cache and main
//   memory. Stores are queued in order in a circular FIFO and drained to
//   memory one at a time over a req/ack handshake. A combinational lookup
//   forwards the youngest buffered data for a cache miss address, so a miss
//   never returns stale memory contents.
//
//   Optional feature macro: WB_COALESCE_EN
//     When defined, a store whose word address matches a buffered entry
//     overwrites that entry's data in place. The head entry is never touched
//     while it is being presented to memory.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   wr_valid/ready    store handshake from the cache (wr_addr, wr_data)
//   lk_addr           forwarding lookup address -> fwd_hit, fwd_data
//   mem_req/ack       drain handshake to memory (mem_addr, mem_wdata)
//   count/empty/full  occupancy status
module cache_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int WA_W  = ADDR_W - 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WA_W-1:0]   ent_addr_q [DEPTH];
  logic [WA_W-1:0]   ent_addr_d [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];
  logic [DATA_W-1:0] ent_data_d [DEPTH];

  logic              coal_hit;
  logic [PW-1:0]     coal_idx;
  logic              push, pop, coal_wr;

  // Byte-offset bits carry no information at word granularity.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{wr_addr[1:0], lk_addr[1:0]};

  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign mem_req   = mem_req_q;
  assign mem_addr  = {ent_addr_q[rd_ptr_q], 2'b00};
  assign mem_wdata = ent_data_q[rd_ptr_q];

  // Forwarding: walk entries oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q && ent_addr_q[idx] == lk_addr[ADDR_W-1:2]) begin
        fwd_hit  = 1'b1;
        fwd_data = ent_data_q[idx];
      end
    end
  end

`ifdef WB_COALESCE_EN
  // Youngest matching entry, skipping the head while memory may be sampling it.
  always_comb begin
    logic [PW-1:0] idx;
    coal_hit = 1'b0;
    coal_idx = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (CW'(k) < count_q && ent_addr_q[idx] == wr_addr[ADDR_W-1:2] &&
          !(k == 0 && state_q == REQ)) begin
        coal_hit = 1'b1;
        coal_idx = idx;
      end
    end
  end
`else
  assign coal_hit = 1'b0;
  assign coal_idx = '0;
`endif

  // A pop frees its slot only from the next cycle, so readiness uses the
  // registered count alone.
  assign wr_ready = !full || coal_hit;
  assign coal_wr  = wr_valid && wr_ready && coal_hit;
  assign push     = wr_valid && wr_ready && !coal_hit;
  assign pop      = (state_q == REQ) && mem_ack;

  always_comb begin
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    mem_req_d  = mem_req_q;

    if (push) begin
      ent_addr_d[wr_ptr_q] = wr_addr[ADDR_W-1:2];
      ent_data_d[wr_ptr_q] = wr_data;
      wr_ptr_d             = wr_ptr_q + PW'(1);
    end
    if (coal_wr) ent_data_d[coal_idx] = wr_data;
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);

    // Drain FSM: one request per entry, returning to IDLE after each ack,
    // which caps throughput at one write every two cycles.
    case (state_q)
      IDLE: if (!empty) begin
        state_d   = REQ;
        mem_req_d = 1'b1;
      end
      REQ: if (mem_ack) begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_req_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
    end
  end

endmodule

// File: tb/tb_cache_write_buffer.sv
// Testbench for cache_write_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based model of the buffer contents.
module tb_cache_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0, wr_ready;
  logic [AW-1:0] wr_addr = '0, lk_addr = '0, mem_addr;
  logic [DW-1:0] wr_data = '0, fwd_data, mem_wdata;
  logic          fwd_hit, mem_req, mem_ack = 1'b0, empty, full;
  logic [CW-1:0] count;

  cache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .lk_addr(lk_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {logic [29:0] a; logic [31:0] d;} ent_t;
  typedef struct {logic [31:0] a; logic [31:0] d;} wr_t;

  ent_t q[$];       // buffered stores, oldest first
  bit   m_req;      // memory request outstanding in the model
  wr_t  wlog[$];    // writes memory accepted, in order

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int youngest(input logic [29:0] a, input bit skip_head);
    int r = -1;
    for (int j = 0; j < q.size(); j++)
      if (q[j].a == a && !(skip_head && j == 0)) r = j;
    return r;
  endfunction

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cyc(input bit v, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] lk, input bit ack);
    int fj, cj, sz;
    bit rdy, acc, pop;
    wr_valid = v; wr_addr = a; wr_data = d; lk_addr = lk; mem_ack = ack;
    #3;
    fj = youngest(lk[31:2], 1'b0);
    cj = -1;
`ifdef WB_COALESCE_EN
    cj = youngest(a[31:2], m_req);
`endif
    sz  = q.size();
    rdy = (sz < DEPTH) || (cj >= 0);
    chk("wr_ready", wr_ready, rdy);
    chk("fwd_hit", fwd_hit, fj >= 0);
    chk("fwd_data", fwd_data, (fj >= 0) ? q[fj].d : 32'h0);
    chk("mem_req", mem_req, m_req);
    chk("count", count, sz);
    chk("empty", empty, sz == 0);
    chk("full", full, sz == DEPTH);
    if (m_req) begin
      chk("mem_addr", mem_addr, {q[0].a, 2'b00});
      chk("mem_wdata", mem_wdata, q[0].d);
    end
    acc = v && rdy;
    pop = m_req && ack;
    if (pop) wlog.push_back('{mem_addr, mem_wdata});
    @(posedge clk);
    #1;
    if (acc && cj >= 0) q[cj].d = d;
    if (pop) void'(q.pop_front());
    if (acc && cj < 0) q.push_back('{a[31:2], d});
    m_req = m_req ? !ack : (sz > 0);
  endtask

  task automatic do_reset();
    wr_valid = 1'b0; mem_ack = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_wr_ready", wr_ready, 1);
    q.delete();
    m_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int n);
    repeat (n) cyc(1'b0, 32'h0, 32'h0, 32'h0, m_req);
  endtask

  initial begin
    m_req = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    do_reset();

    // Fill with memory stalled.
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h100 + 4 * i, 32'hA + i, 32'h0, 1'b0);
    repeat (3) cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("fill_full", full, 1);
    chk("fill_ready", wr_ready, 0);
    chk("fill_count", count, 4);
    chk("fill_req", mem_req, 1);
    chk("fill_addr", mem_addr, 32'h100);
    chk("fill_data", mem_wdata, 32'hA);

    // Drain in order.
    wlog.delete();
    drain(12);
    chk("drain_n", wlog.size(), 4);
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      chk("drain_addr", wlog[i].a, 32'h100 + 4 * i);
      chk("drain_data", wlog[i].d, 32'hA + i);
    end
    chk("drain_empty", empty, 1);
    chk("drain_req", mem_req, 0);

    // Forwarding of the youngest match.
    cyc(1'b1, 32'h200, 32'h11, 32'h203, 1'b0);
    cyc(1'b1, 32'h200, 32'h22, 32'h203, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 32'h203, 1'b0);
    chk("fwd_hit_y", fwd_hit, 1);
    chk("fwd_data_y", fwd_data, 32'h22);
`ifdef WB_COALESCE_EN
    chk("fwd_count", count, 1);
`else
    chk("fwd_count", count, 2);
`endif
    cyc(1'b0, 32'h0, 32'h0, 32'h204, 1'b0);
    chk("fwd_miss", fwd_hit, 0);
    chk("fwd_miss_data", fwd_data, 0);
    drain(10);

    // Repeated store to the same word.
    cyc(1'b1, 32'h300, 32'h1, 32'h0, 1'b0);
    cyc(1'b1, 32'h304, 32'h2, 32'h0, 1'b0);
    cyc(1'b1, 32'h304, 32'h3, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    wlog.delete();
`ifdef WB_COALESCE_EN
    chk("coal_count", count, 2);
`else
    chk("coal_count", count, 3);
`endif
    drain(10);
    chk("coal_w0_addr", wlog.size() > 0 ? wlog[0].a : 32'hFFFF_FFFF, 32'h300);
    chk("coal_w0_data", wlog.size() > 0 ? wlog[0].d : 32'hFFFF_FFFF, 32'h1);
`ifdef WB_COALESCE_EN
    chk("coal_n", wlog.size(), 2);
    chk("coal_w1_data", wlog.size() > 1 ? wlog[1].d : 32'hFFFF_FFFF, 32'h3);
`else
    chk("coal_n", wlog.size(), 3);
`endif

    // Reset while a request is outstanding, then a late ack.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h400 + 4 * i, 32'h50 + i, 32'h0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    chk("pre_rst_req", mem_req, 1);
    do_reset();
    cyc(1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("late_ack_count", count, 0);
    chk("late_ack_req", mem_req, 0);

    // Random traffic over a small address pool to exercise hits and wrap.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 6,
          {$urandom_range(0, 7), 2'b00} + 32'h800 + $urandom_range(0, 3) * 0,
          $urandom,
          {$urandom_range(0, 7), 2'b00} + 32'h800 + $urandom_range(0, 3),
          $urandom_range(0, 1));
    end
    drain(12);
    chk("final_empty", empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
